relay_oscillation_identifier: RTL and testbench
===============================================

Name: relay_oscillation_identifier

Overview:
Relay-feedback (Åström–Hägglund) excitation and measurement engine for the motor PID loop. While active, it replaces the PID output with a hysteretic ±RELAY_AMP relay command and watches the resulting limit cycle. It measures the ultimate period Tu and the ultimate gain Ku, and publishes both to the gain-calculation stage as a done/fail result. It is the plant-driving end of the tuning path; the Z-N gain tuner consumes its outputs.

Parameters:
ERROR_WIDTH, 16, width of the signed error input (setpoint − measurement).
CMD_WIDTH, 16, width of the signed relay command output.
RELAY_AMP, 4096, relay amplitude d (positive, < 2^(CMD_WIDTH−1)).
HYST, 64, relay hysteresis band, in error LSBs.
SETTLE_SWITCHES, 4, relay switches discarded before measurement.
MEASURE_PERIODS, 4, full oscillation periods averaged; must be a power of two.
TIMEOUT, 24_000_000, maximum sample ticks from start to measurement complete.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sample_en  in  1  one-cycle PID sample strobe; error is valid on this cycle
error  in  ERROR_WIDTH  signed loop error
start  in  1  start-identification pulse
relay_cmd  out  CMD_WIDTH  signed relay drive to the motor command mux
relay_active  out  1  high while relay_cmd must override the PID output
busy  out  1  high in every state other than IDLE, DONE and FAIL
ku_est  out  16  Ku, unsigned Q8.8
tu_est  out  32  Tu, in sample ticks
ident_done  out  1  level; result valid
ident_fail  out  1  level; timeout occurred

Behaviour:
- Reset values: relay_cmd = 0, relay_active = 0, busy = 0, ku_est = 0, tu_est = 0, ident_done = 0, ident_fail = 0. State = IDLE.
- States: IDLE → SETTLE → MEASURE → DIVIDE → DONE. Any state from SETTLE through MEASURE can go to FAIL.
- start is accepted only in IDLE, DONE or FAIL; it is ignored while busy.
- On an accepted start:
  - clear ident_done, ident_fail and all counters;
  - set relay_cmd = +RELAY_AMP and relay_active = 1 on the next cycle;
  - enter SETTLE.
- Relay law, evaluated only on sample_en:
  - if relay_cmd > 0 and error < −HYST, switch to −RELAY_AMP;
  - if relay_cmd < 0 and error > +HYST, switch to +RELAY_AMP;
  - otherwise hold.
  - The comparison is signed. relay_cmd updates one clk after the sample_en cycle.
- SETTLE: count switches. After SETTLE_SWITCHES switches, enter MEASURE on the same cycle as that switch. That switch starts the measurement window.
- MEASURE:
  - per sample_en, increment a 32-bit window counter (saturating) and track the signed max and min of error;
  - the switch that starts the window and the error sample at that switch are included;
  - the window ends at the 2·MEASURE_PERIODS-th following switch.
  - At window end:
    - tu_est = window_count >> log2(MEASURE_PERIODS);
    - amplitude a = (max − min) >> 1, computed unsigned at ERROR_WIDTH+1 bits;
    - relay_cmd → 0 and relay_active → 0;
    - enter DIVIDE.
- Timeout: a 32-bit counter counts sample_en ticks from start. Reaching TIMEOUT in SETTLE or MEASURE gives: relay_cmd = 0, relay_active = 0, ident_fail = 1, enter FAIL. ku_est and tu_est are unchanged.
- DIVIDE: ku_est = (RELAY_AMP·326) / a, where 326 ≈ 4·256/π.
  - Use an unsigned 32/16 serial restoring divider taking exactly 32 clk.
  - Quotient > 0xFFFF, or a = 0, gives ku_est = 0xFFFF.
  - Then enter DONE with ident_done = 1.
- DONE and FAIL hold their outputs until the next accepted start.
- Reset mid-operation: return to IDLE and set outputs to reset values on the next edge. A divide in progress is discarded.
- sample_en asserted on the same cycle as an accepted start is ignored.

Decomposition:
- Shared package pid_tune_pkg holds:
  - state encoding;
  - the constant KU_SCALE_Q8 = 326;
  - Q8.8 gain typedef / width constants shared with the gain tuner.
- One sub-module: serial_divider, 32-bit dividend / 16-bit divisor, start/done handshake, 32-cycle latency, saturating quotient output.

Test Plan:
Bench parameters: defaults, with sample_en every cycle and TIMEOUT = 5000 unless stated.
1. Square-wave error: +500 for 100 samples, then −500 for 100, repeating; pulse start → tu_est = 200, ku_est = 1335296/500 = 2670, ident_done = 1, relay_active drops at window end, done asserts 32+ clk later.
2. Constant error = +1000 → relay_cmd stays +4096 and never switches; at 5000 ticks ident_fail = 1, relay_cmd = 0, ku_est = 0.
3. Error alternating ±50 every 10 samples (inside HYST = 64) → no switches, ident_fail after timeout.
4. Square wave ±65, period 20 samples → a = 65, ku_est = 20543, tu_est = 20; repeat with HYST = 0 and error ±1 → a = 1, quotient 1335296 saturates to ku_est = 0xFFFF.
5. Assert reset during MEASURE and again during DIVIDE → the next cycle has relay_cmd = 0, relay_active = 0 and busy = 0; a new start then completes test 1 correctly.
6. start pulsed during MEASURE → ignored, result identical to test 1; start in DONE → ident_done clears next cycle and relay_cmd = +4096.

Source files
------------

// File: rtl/pid_tune_pkg.sv
// Shared definitions for the PID auto-tuning path: identifier state encoding
// and the Q8.8 gain format handed to the Z-N gain tuner.
package pid_tune_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DIVIDE,
    ST_DONE,
    ST_FAIL
  } tune_state_t;

  // 4*256/pi, so that Ku = (d * KU_SCALE_Q8) / a lands directly in Q8.8
  localparam int KU_SCALE_Q8 = 326;

  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 8;

  typedef logic [GAIN_W-1:0] gain_q8_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned 32/16 restoring divider: one quotient bit per clock, 32 clocks from
// start to done, quotient saturated to 16 bits (divide-by-zero also saturates).
module serial_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic        done
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] num;
  logic [15:0] rem;
  logic [15:0] den;
  logic [16:0] trial;
  logic        take;
  logic [15:0] rem_next;
  logic [31:0] num_next;

  function automatic logic [15:0] sat_q16(input logic [31:0] q, input logic [15:0] d);
    if (d == '0 || q[31:16] != '0) return 16'hFFFF;
    return q[15:0];
  endfunction

  always_comb begin
    trial    = {rem, num[31]};
    take     = (trial >= {1'b0, den});
    rem_next = take ? 16'(trial - {1'b0, den}) : trial[15:0];
    num_next = {num[30:0], take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Dividend register doubles as the quotient shift register
  always_ff @(posedge clk) begin
    if (start) begin
      num <= dividend;
      rem <= '0;
      den <= divisor;
    end else if (busy) begin
      num <= num_next;
      rem <= rem_next;
      if (cnt == 5'd31) quotient <= sat_q16(num_next, den);
    end
  end

endmodule

// File: rtl/relay_oscillation_identifier.sv
// Relay-feedback limit-cycle exciter: drives a hysteretic +/-d relay, measures
// the ultimate period Tu and amplitude, then derives Ku = 4d/(pi*a) in Q8.8.
module relay_oscillation_identifier
  import pid_tune_pkg::*;
#(
  parameter int ERROR_WIDTH     = 16,
  parameter int CMD_WIDTH       = 16,
  parameter int RELAY_AMP       = 4096,
  parameter int HYST            = 64,
  parameter int SETTLE_SWITCHES = 4,
  parameter int MEASURE_PERIODS = 4,
  parameter int TIMEOUT         = 24_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_en,
  input  logic signed [ERROR_WIDTH-1:0] error,
  input  logic                          start,
  output logic signed [CMD_WIDTH-1:0]   relay_cmd,
  output logic                          relay_active,
  output logic                          busy,
  output gain_q8_t                      ku_est,
  output logic [31:0]                   tu_est,
  output logic                          ident_done,
  output logic                          ident_fail
);

  localparam int SW_W   = $clog2(SETTLE_SWITCHES + 2 * MEASURE_PERIODS + 1);
  localparam int MP_SH  = $clog2(MEASURE_PERIODS);
  localparam logic [SW_W-1:0] SETTLE_LAST = SW_W'(SETTLE_SWITCHES - 1);
  localparam logic [SW_W-1:0] WIN_LAST    = SW_W'(2 * MEASURE_PERIODS - 1);
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [31:0] DIVIDEND  = 32'(RELAY_AMP * KU_SCALE_Q8);
  localparam logic signed [CMD_WIDTH-1:0]   AMP_POS  = CMD_WIDTH'(RELAY_AMP);
  localparam logic signed [ERROR_WIDTH-1:0] HYST_POS = ERROR_WIDTH'(HYST);
  localparam logic signed [ERROR_WIDTH-1:0] HYST_NEG = ERROR_WIDTH'(-HYST);

  tune_state_t state, state_next;

  logic [SW_W-1:0]               sw_cnt;
  logic [31:0]                   tmo_cnt;
  logic [31:0]                   win_cnt;
  logic signed [ERROR_WIDTH-1:0] err_max, err_min;
  logic [ERROR_WIDTH:0]          span;
  logic [ERROR_WIDTH-1:0]        amp;
  logic in_run, start_ok, relay_sw, tmo_hit, win_open, win_end, win_track;
  logic div_done;
  logic [15:0] div_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign in_run    = (state == ST_SETTLE) || (state == ST_MEASURE);
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
  assign relay_sw  = sample_en &&
                     ((!relay_cmd[CMD_WIDTH-1] && relay_cmd != '0 && error < HYST_NEG) ||
                      (relay_cmd[CMD_WIDTH-1] && error > HYST_POS));
  assign tmo_hit   = in_run && sample_en && ((tmo_cnt + 32'd1) >= TIMEOUT_C);
  assign win_open  = (state == ST_SETTLE) && relay_sw && !tmo_hit && (sw_cnt == SETTLE_LAST);
  assign win_end   = (state == ST_MEASURE) && relay_sw && !tmo_hit && (sw_cnt == WIN_LAST);
  assign win_track = (state == ST_MEASURE) && sample_en && !tmo_hit && !win_end;
  assign busy      = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_DIVIDE);

  // Peak-to-peak is widened by one bit so max-min of full-scale samples cannot wrap
  assign span = {err_max[ERROR_WIDTH-1], err_max} - {err_min[ERROR_WIDTH-1], err_min};
  assign amp  = ERROR_WIDTH'(span >> 1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (start) state_next = ST_SETTLE;
      ST_SETTLE:  if (tmo_hit) state_next = ST_FAIL; else if (win_open) state_next = ST_MEASURE;
      ST_MEASURE: if (tmo_hit) state_next = ST_FAIL; else if (win_end) state_next = ST_DIVIDE;
      ST_DIVIDE:  if (div_done) state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      relay_cmd    <= '0;
      relay_active <= 1'b0;
      ku_est       <= '0;
      tu_est       <= '0;
      ident_done   <= 1'b0;
      ident_fail   <= 1'b0;
      sw_cnt       <= '0;
      tmo_cnt      <= '0;
      win_cnt      <= '0;
    end else begin
      if (start_ok) begin
        relay_cmd    <= AMP_POS;
        relay_active <= 1'b1;
      end else if (tmo_hit || win_end) begin
        relay_cmd    <= '0;
        relay_active <= 1'b0;
      end else if (in_run && relay_sw) begin
        relay_cmd <= -relay_cmd;
      end

      if (start_ok)                     tmo_cnt <= '0;
      else if (in_run && sample_en)     tmo_cnt <= sat_inc32(tmo_cnt);

      if (start_ok || win_open)         sw_cnt <= '0;
      else if (in_run && relay_sw && !tmo_hit) sw_cnt <= sw_cnt + SW_W'(1);

      if (start_ok)                     win_cnt <= '0;
      else if (win_open)                win_cnt <= 32'd1;
      else if (win_track)               win_cnt <= sat_inc32(win_cnt);

      if (win_end) tu_est <= win_cnt >> MP_SH;

      if (start_ok) begin
        ident_done <= 1'b0;
        ident_fail <= 1'b0;
      end else if (tmo_hit) begin
        ident_fail <= 1'b1;
      end else if (state == ST_DIVIDE && div_done) begin
        ku_est     <= div_q;
        ident_done <= 1'b1;
      end
    end
  end

  // Window extremes include the opening switch sample, exclude the closing one
  always_ff @(posedge clk) begin
    if (win_open) begin
      err_max <= error;
      err_min <= error;
    end else if (win_track) begin
      if (error > err_max) err_max <= error;
      if (error < err_min) err_min <= error;
    end
  end

  serial_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (win_end),
    .dividend (DIVIDEND),
    .divisor  (16'(amp)),
    .quotient (div_q),
    .done     (div_done)
  );

endmodule

// File: tb/tb_relay_oscillation_identifier.sv
// Bench for relay_oscillation_identifier: two instances (HYST=64 and HYST=0)
// driven by directed and random error waveforms, checked every cycle.
module tb_relay_oscillation_identifier;

  localparam int TMO  = 5000;
  localparam int AMP  = 4096;
  localparam int KNUM = 4096 * 326;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_en = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] error = '0;

  logic signed [15:0] cmd_a, cmd_b;
  logic act_a, act_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;
  logic [15:0] ku_a, ku_b;
  logic [31:0] tu_a, tu_b;

  int n_chk = 0;
  int n_err = 0;
  bit started = 1'b0;

  int w_amp = 0, w_half = 0, w_noise = 0, se_pct = 100, phase = 0;

  // Reference model state per instance: 0 idle,1 settle,2 measure,3 divide,4 done,5 fail
  int hy[2] = '{64, 0};
  int m_st[2], m_cmd[2], m_swc[2], m_mx[2], m_mn[2], m_ku[2], m_dcnt[2], m_a[2];
  longint m_tmo[2], m_win[2], m_tu[2];
  bit m_act[2], m_done[2], m_fail[2];

  always #5 clk = ~clk;

  relay_oscillation_identifier #(.HYST(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .error(error), .start(start),
    .relay_cmd(cmd_a), .relay_active(act_a), .busy(busy_a), .ku_est(ku_a),
    .tu_est(tu_a), .ident_done(done_a), .ident_fail(fail_a));

  relay_oscillation_identifier #(.HYST(0), .TIMEOUT(TMO)) dut_h0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .error(error), .start(start),
    .relay_cmd(cmd_b), .relay_active(act_b), .busy(busy_b), .ku_est(ku_b),
    .tu_est(tu_b), .ident_done(done_b), .ident_fail(fail_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic int ku_of(input int a);
    if (a == 0) return 65535;
    return (KNUM / a > 65535) ? 65535 : KNUM / a;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int st, cmd, swc, mx, mn, ku, dcnt, a, e;
      longint tmo, win, tu;
      bit act, dn, fl, sw;
      st = m_st[i]; cmd = m_cmd[i]; swc = m_swc[i]; mx = m_mx[i]; mn = m_mn[i];
      ku = m_ku[i]; dcnt = m_dcnt[i]; a = m_a[i]; tmo = m_tmo[i]; win = m_win[i];
      tu = m_tu[i]; act = m_act[i]; dn = m_done[i]; fl = m_fail[i];
      if (reset) begin
        st = 0; cmd = 0; act = 0; ku = 0; tu = 0; dn = 0; fl = 0;
        swc = 0; tmo = 0; win = 0; dcnt = 0;
      end else begin
        case (st)
          0, 4, 5: if (start) begin
            st = 1; cmd = AMP; act = 1; dn = 0; fl = 0; swc = 0; tmo = 0; win = 0;
          end
          1, 2: if (sample_en) begin
            e = int'(error);
            sw = (cmd > 0 && e < -hy[i]) || (cmd < 0 && e > hy[i]);
            tmo++;
            if (tmo >= TMO) begin
              cmd = 0; act = 0; fl = 1; st = 5;
            end else if (st == 1) begin
              if (sw) begin
                cmd = -cmd; swc++;
                if (swc == 4) begin st = 2; swc = 0; win = 1; mx = e; mn = e; end
              end
            end else if (sw && swc == 7) begin
              tu = win / 4; a = (mx - mn) / 2; cmd = 0; act = 0; st = 3; dcnt = 0;
            end else begin
              if (sw) begin cmd = -cmd; swc++; end
              if (win < 64'hFFFF_FFFF) win++;
              if (e > mx) mx = e;
              if (e < mn) mn = e;
            end
          end
          3: begin
            dcnt++;
            if (dcnt == 33) begin ku = ku_of(a); dn = 1; st = 4; end
          end
          default: ;
        endcase
      end
      m_st[i] <= st; m_cmd[i] <= cmd; m_swc[i] <= swc; m_mx[i] <= mx; m_mn[i] <= mn;
      m_ku[i] <= ku; m_dcnt[i] <= dcnt; m_a[i] <= a; m_tmo[i] <= tmo; m_win[i] <= win;
      m_tu[i] <= tu; m_act[i] <= act; m_done[i] <= dn; m_fail[i] <= fl;
    end
    started <= 1'b1;
  end

  task automatic cmp_dut(input int i, input logic signed [15:0] c, input logic a,
                         input logic bz, input logic [15:0] k, input logic [31:0] t,
                         input logic d, input logic f);
    chk($sformatf("relay_cmd%0d", i), 64'(c), 64'(m_cmd[i]));
    chk($sformatf("relay_active%0d", i), 64'(a), 64'(m_act[i]));
    chk($sformatf("busy%0d", i), 64'(bz), 64'(m_st[i] >= 1 && m_st[i] <= 3));
    chk($sformatf("ku_est%0d", i), 64'(k), 64'(m_ku[i]));
    chk($sformatf("tu_est%0d", i), 64'(t), 64'(m_tu[i]));
    chk($sformatf("ident_done%0d", i), 64'(d), 64'(m_done[i]));
    chk($sformatf("ident_fail%0d", i), 64'(f), 64'(m_fail[i]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_dut(0, cmd_a, act_a, busy_a, ku_a, tu_a, done_a, fail_a);
      cmp_dut(1, cmd_b, act_b, busy_b, ku_b, tu_b, done_b, fail_b);
    end
  end

  task automatic cycle(input bit st);
    int e;
    @(negedge clk);
    start = st;
    if (se_pct >= 100 || $urandom_range(0, 99) < se_pct) begin
      if (w_half == 0) e = w_amp;
      else e = ((phase / w_half) % 2 == 0) ? w_amp : -w_amp;
      if (w_noise > 0) e = e + int'($urandom_range(0, 2 * w_noise)) - w_noise;
      if (e > 32767) e = 32767;
      if (e < -32768) e = -32768;
      error = 16'(e);
      sample_en = 1'b1;
      phase++;
    end else begin
      sample_en = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0);
  endtask

  // Start carries a sample that must be ignored; returns one cycle after the start edge
  task automatic do_start();
    @(negedge clk);
    start = 1'b1; sample_en = 1'b1; error = -16'sd1000;
    @(negedge clk);
    start = 1'b0; sample_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_wave(input int amp, input int half, input int noise, input int pct);
    w_amp = amp; w_half = half; w_noise = noise; se_pct = pct; phase = 0;
  endtask

  task automatic check_t1(input string tag);
    chk({tag, "_ku"}, 64'(ku_a), 64'd2670);
    chk({tag, "_tu"}, 64'(tu_a), 64'd200);
    chk({tag, "_done"}, 64'(done_a), 64'd1);
    chk({tag, "_act"}, 64'(act_a), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd", 64'(cmd_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ku", 64'(ku_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);

    // Square wave +/-500, half period 100
    set_wave(500, 100, 0, 100);
    do_start();
    chk("t1_start_cmd", 64'(cmd_a), 64'(AMP));
    run(1300);
    check_t1("t1");
    chk("t1_model_ku", 64'(m_ku[0]), 64'd2670);
    chk("t1_model_tu", 64'(m_tu[0]), 64'd200);
    chk("t1_h0_ku", 64'(ku_b), 64'd2670);

    // Restart from DONE
    set_wave(500, 100, 0, 100);
    do_start();
    chk("t6_done_clr", 64'(done_a), 64'd0);
    chk("t6_cmd", 64'(cmd_a), 64'(AMP));
    run(1300);
    check_t1("t6b");

    // Start pulse during MEASURE is ignored
    set_wave(500, 100, 0, 100);
    do_start();
    run(700);
    cycle(1'b1);
    run(700);
    check_t1("t6a");

    // Reset during MEASURE, then during DIVIDE
    set_wave(500, 100, 0, 100);
    do_start();
    run(600);
    pulse_reset();
    chk("t5m_cmd", 64'(cmd_a), 64'd0);
    chk("t5m_act", 64'(act_a), 64'd0);
    chk("t5m_busy", 64'(busy_a), 64'd0);
    set_wave(500, 100, 0, 100);
    do_start();
    guard = 0;
    while (!(busy_a && !act_a) && guard < 2000) begin cycle(1'b0); guard++; end
    chk("t5_reach_divide", 64'(guard < 2000), 64'd1);
    run(5);
    pulse_reset();
    chk("t5d_cmd", 64'(cmd_a), 64'd0);
    chk("t5d_act", 64'(act_a), 64'd0);
    chk("t5d_busy", 64'(busy_a), 64'd0);
    chk("t5d_ku", 64'(ku_a), 64'd0);
    set_wave(500, 100, 0, 100);
    do_start();
    run(1300);
    check_t1("t5");

    // Constant error: relay never switches, timeout
    pulse_reset();
    set_wave(1000, 0, 0, 100);
    do_start();
    run(4990);
    chk("t2_hold_cmd", 64'(cmd_a), 64'(AMP));
    chk("t2_no_fail", 64'(fail_a), 64'd0);
    run(15);
    chk("t2_fail", 64'(fail_a), 64'd1);
    chk("t2_cmd", 64'(cmd_a), 64'd0);
    chk("t2_ku", 64'(ku_a), 64'd0);
    chk("t2_model_fail", 64'(m_fail[0]), 64'd1);

    // Error inside the hysteresis band
    set_wave(50, 10, 0, 100);
    do_start();
    run(5005);
    chk("t3_fail", 64'(fail_a), 64'd1);
    chk("t3_act", 64'(act_a), 64'd0);

    // Small square waves
    set_wave(65, 10, 0, 100);
    do_start();
    run(200);
    chk("t4_ku", 64'(ku_a), 64'd20543);
    chk("t4_tu", 64'(tu_a), 64'd20);
    chk("t4_model_ku", 64'(m_ku[0]), 64'd20543);
    set_wave(1, 10, 0, 100);
    do_start();
    run(200);
    chk("t4_h0_ku", 64'(ku_b), 64'hFFFF);
    chk("t4_h0_tu", 64'(tu_b), 64'd20);
    chk("t4_h0_done", 64'(done_b), 64'd1);
    chk("t4_h64_busy", 64'(busy_a), 64'd1);
    run(5000);
    chk("t4_h64_fail", 64'(fail_a), 64'd1);
    chk("t4_h64_ku_kept", 64'(ku_a), 64'd20543);

    // Random waveforms, sample rates, noise and stray starts
    for (int ep = 0; ep < 20; ep++) begin
      set_wave(int'($urandom_range(0, 3000)), int'($urandom_range(1, 40)),
               int'($urandom_range(0, 100)), int'($urandom_range(40, 100)));
      phase = int'($urandom_range(0, 80));
      do_start();
      for (int k = 0; k < 1200; k++) cycle($urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
